// File: rtl/imem_fetch_sequencer.sv
// Byte-serial instruction fetch: four big-endian byte reads per word,
// held at the IF/ID boundary until accepted or redirected.
package imem_fetch_sequencer_pkg;
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;
endpackage

module imem_fetch_sequencer
  import imem_fetch_sequencer_pkg::*;
#(
  parameter int LEN_ADDRESS     = 32,
  parameter int LEN_INSTRUCTION = 32,
  parameter int LEN_BYTE        = 8,
  parameter logic [LEN_ADDRESS-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [LEN_ADDRESS-1:0]     branch_address,
  output logic [LEN_ADDRESS-1:0]     mem_address,
  output logic                       mem_read,
  input  logic [LEN_BYTE-1:0]        mem_data,
  output logic [LEN_INSTRUCTION-1:0] instruction,
  output logic [LEN_ADDRESS-1:0]     pc_out,
  output logic                       valid,
  input  logic                       accept
);

  localparam int NB = LEN_INSTRUCTION / LEN_BYTE;
  localparam int IW = $clog2(NB);
  localparam logic [LEN_ADDRESS-1:0] STEP  = LEN_ADDRESS'(NB);
  localparam logic [LEN_ADDRESS-1:0] ALIGN = ~(STEP - 1'b1);
  localparam logic [LEN_ADDRESS-1:0] PC0   = RESET_PC & ALIGN;

  fetch_state_e               state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [LEN_ADDRESS-1:0]     pc_q, pc_d;
  logic [LEN_ADDRESS-1:0]     pcout_q, pcout_d;
  logic [LEN_INSTRUCTION-1:0] instr_q, instr_d;
  logic                       valid_q, valid_d;
  logic                       last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      idx_q   <= '0;
      pc_q    <= PC0;
      pcout_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      pcout_q <= pcout_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign last = (idx_q == IW'(NB - 1));

  // Redirect outranks freeze and accept; a partial word is simply dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    pcout_d = pcout_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (branch_taken) begin
      state_d = FETCH;
      idx_d   = '0;
      pc_d    = branch_address & ALIGN;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (!freeze) begin
            for (int b = 0; b < NB; b++) begin
              if (idx_q == IW'(b)) begin
                instr_d[LEN_BYTE*(NB-1-b) +: LEN_BYTE] = mem_data;
              end
            end
            idx_d = idx_q + IW'(1);
            if (last) begin
              state_d = HOLD;
              idx_d   = '0;
              valid_d = 1'b1;
              pcout_d = pc_q + STEP;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            state_d = FETCH;
            valid_d = 1'b0;
            pc_d    = pc_q + STEP;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_read    = (state_q == FETCH) && !freeze && rst_n;
    mem_address = {pc_q[LEN_ADDRESS-1:IW], idx_q};
  end

  assign instruction = instr_q;
  assign pc_out      = pcout_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: cycle table, corner sequences,
// and a randomized accept/freeze run checked against a word scoreboard.
module tb_imem_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [7:0]  mem_data;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid;
  logic        accept;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] ba;
    logic        acc;
    logic [31:0] ea;
    logic        er;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  imem_fetch_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .freeze(freeze),
    .branch_taken(branch_taken),
    .branch_address(branch_address),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_data(mem_data),
    .instruction(instruction),
    .pc_out(pc_out),
    .valid(valid),
    .accept(accept)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'd0:   return 8'hE0;
      32'd1:   return 8'h00;
      32'd2:   return 8'h00;
      32'd3:   return 8'h00;
      32'd4:   return 8'hE3;
      32'd5:   return 8'hA0;
      32'd6:   return 8'h00;
      32'd7:   return 8'h14;
      default: return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {mb(a), mb(a + 32'd1), mb(a + 32'd2), mb(a + 32'd3)};
  endfunction

  always_comb mem_data = mb(mem_address);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic frz, input logic br,
                              input logic [31:0] ba, input logic acc,
                              input logic [31:0] ea, input logic er,
                              input logic ev, input logic [31:0] ei,
                              input logic [31:0] ep);
    vec_t v;
    v.frz = frz; v.br = br; v.ba = ba; v.acc = acc;
    v.ea = ea; v.er = er; v.ev = ev; v.ei = ei; v.ep = ep;
    tbl.push_back(v);
  endfunction

  function automatic void fet(input logic [31:0] ea);
    add(1'b0, 1'b0, 32'h0, 1'b0, ea, 1'b1, 1'b0, 32'h0, 32'h0);
  endfunction

  initial begin
    exp_t        e;
    logic [31:0] exp_pc;
    int          words;
    bit          got;

    rst_n = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_address = '0;
    accept = 1'b0;

    fet(32'h0); fet(32'h1); fet(32'h2); fet(32'h3);
    add(0, 0, 0, 0, 32'h0, 0, 1, mword(32'h0), 32'h4);
    add(1, 0, 0, 0, 32'h0, 0, 1, mword(32'h0), 32'h4);
    add(0, 0, 0, 1, 32'h0, 0, 1, mword(32'h0), 32'h4);
    fet(32'h4);
    add(1, 0, 0, 0, 32'h5, 0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h5, 0, 0, 0, 0);
    fet(32'h5); fet(32'h6); fet(32'h7);
    add(0, 0, 0, 0, 32'h4, 0, 1, mword(32'h4), 32'h8);
    add(0, 0, 0, 1, 32'h4, 0, 1, mword(32'h4), 32'h8);
    fet(32'h8); fet(32'h9);
    add(0, 1, 32'h99, 0, 32'hA, 1, 0, 0, 0);
    fet(32'h98); fet(32'h99); fet(32'h9A); fet(32'h9B);
    add(0, 1, 32'h40, 1, 32'h98, 0, 1, mword(32'h98), 32'h9C);
    fet(32'h40); fet(32'h41); fet(32'h42);
    add(1, 1, 32'hFFFF_FFFC, 0, 32'h43, 0, 0, 0, 0);
    fet(32'hFFFF_FFFC); fet(32'hFFFF_FFFD);
    fet(32'hFFFF_FFFE); fet(32'hFFFF_FFFF);
    add(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1, mword(32'hFFFF_FFFC), 32'h0);
    fet(32'h0); fet(32'h1);

    @(negedge clk);
    #1;
    chk("rst valid", valid, 0);
    chk("rst read", mem_read, 0);
    chk("rst instr", instruction, 0);
    chk("rst pc_out", pc_out, 0);
    chk("rst addr", mem_address, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      freeze = tbl[i].frz;
      branch_taken = tbl[i].br;
      branch_address = tbl[i].ba;
      accept = tbl[i].acc;
      #1;
      chk($sformatf("v%0d addr", i), mem_address, tbl[i].ea);
      chk($sformatf("v%0d read", i), mem_read, tbl[i].er);
      chk($sformatf("v%0d valid", i), valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d instr", i), instruction, tbl[i].ei);
        chk($sformatf("v%0d pc_out", i), pc_out, tbl[i].ep);
      end
    end

    // Asynchronous reset in the middle of a fetch
    @(negedge clk);
    freeze = 1'b0;
    branch_taken = 1'b0;
    accept = 1'b0;
    #1;
    chk("mid addr", mem_address, 32'h2);
    chk("mid read", mem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst read", mem_read, 0);
    chk("arst addr", mem_address, 32'h0);
    chk("arst valid", valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("restart addr0", mem_address, 32'h0);
    chk("restart read", mem_read, 1);
    @(negedge clk);
    #1;
    chk("restart addr1", mem_address, 32'h1);

    // Random accept/freeze run
    @(negedge clk);
    branch_taken = 1'b1;
    branch_address = 32'h0000_0202;
    freeze = 1'($urandom_range(0, 1));
    accept = 1'b0;
    exp_pc = 32'h200;
    e.ins = mword(exp_pc);
    e.pc = exp_pc + 32'd4;
    sb.push_back(e);
    words = 0;
    for (int c = 0; c < 2000 && words < 8; c++) begin
      @(negedge clk);
      branch_taken = 1'b0;
      freeze = 1'($urandom_range(0, 1));
      accept = 1'($urandom_range(0, 1));
      #1;
      chk("sb read", mem_read, !valid && !freeze);
      if (valid && accept) begin
        if (sb.size() == 0) begin
          chk("sb empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("sb%0d instr", words), instruction, e.ins);
          chk($sformatf("sb%0d pc_out", words), pc_out, e.pc);
          words++;
          exp_pc = exp_pc + 32'd4;
          if (words < 8) begin
            e.ins = mword(exp_pc);
            e.pc = exp_pc + 32'd4;
            sb.push_back(e);
          end
        end
      end
    end
    chk("sb words", words, 8);

    // Asynchronous reset while holding a valid word
    @(negedge clk);
    freeze = 1'b0;
    accept = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      #1;
      got = valid;
    end
    chk("hold reached", valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("hrst valid", valid, 0);
    chk("hrst instr", instruction, 0);
    chk("hrst pc_out", pc_out, 0);
    chk("hrst read", mem_read, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("hrst addr0", mem_address, 32'h0);
    chk("hrst fetch", mem_read, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Multi-cycle fetch controller for the byte-organised instruction memory (8-bit entries, big-endian word assembly, word-aligned addressing).
- Owns the program counter and issues four byte reads per instruction through a single byte port.
- Assembles each 32-bit instruction and presents it to the IF/ID boundary with a valid/accept handshake.
- Handles branch redirect and hazard freeze.

Parameters:
- LEN_ADDRESS, 32, width of PC and memory address.
- LEN_INSTRUCTION, 32, width of the assembled instruction.
- LEN_BYTE, 8, width of one memory entry.
- RESET_PC, 0, PC loaded at reset; low two bits ignored.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- freeze  in  1  hazard stall; suspends byte reads.
- branch_taken  in  1  redirect request, sampled each rising edge.
- branch_address  in  LEN_ADDRESS  redirect target; bits [1:0] forced to 00.
- mem_address  out  LEN_ADDRESS  byte address to memory: {pc[LEN_ADDRESS-1:2], byte_idx}.
- mem_read  out  1  byte read strobe.
- mem_data  in  LEN_BYTE  combinational read data for mem_address, same cycle.
- instruction  out  LEN_INSTRUCTION  assembled word.
- pc_out  out  LEN_ADDRESS  address of held instruction + 4.
- valid  out  1  instruction/pc_out are valid.
- accept  in  1  consumer takes instruction this cycle (meaningful only when valid=1).

Behaviour:
- States:
  - FETCH: byte_idx counter 0..3.
  - HOLD: instruction assembled, waiting for accept.
- Reset (rst_n low, asynchronous, any state or mid-fetch):
  - pc=RESET_PC with [1:0]=00; state=FETCH; byte_idx=0.
  - instruction=0; valid=0; pc_out=0.
  - mem_read=0 while rst_n low.
- mem_read = (state==FETCH) && !freeze && rst_n. mem_address is always {pc[31:2], byte_idx}; in HOLD, byte_idx=0.
- FETCH, freeze=0:
  - Capture mem_data into lane (3-byte_idx): byte 0 → instruction[31:24], byte 3 → instruction[7:0].
  - Increment byte_idx.
  - On byte 3 capture: state→HOLD, valid←1, pc_out←pc+4, byte_idx←0.
- FETCH, freeze=1: byte_idx, lanes and pc unchanged; mem_read=0.
- HOLD:
  - freeze has no effect.
  - accept=1: valid←0; pc←pc+4 (modulo 2^LEN_ADDRESS, so 0xFFFFFFFC wraps to 0); state→FETCH.
  - accept=0: all outputs held stable.
- Latency:
  - Unfrozen fetch: 4 cycles. valid rises at the edge ending byte-3 cycle.
  - Accept to next valid: 5 cycles, so throughput is 1 instruction per 5 cycles.
- branch_taken=1 (highest priority, any state, overrides freeze and accept in the same cycle):
  - pc←{branch_address[31:2],00}; byte_idx←0; valid←0; state→FETCH.
  - Any partially assembled word is discarded.
- Simultaneous accept and branch_taken in HOLD: held instruction counts as consumed; PC goes to branch target, not pc+4.
- instruction lanes for bytes not yet re-read keep old values, but valid=0 so they are don't-care.

Test Plan:
- Memory bytes 0..3 = E0 00 00 00, bytes 4..7 = E3 A0 00 14. Release reset, accept=0 → mem_address 0,1,2,3 in cycles 1-4; valid=1 after cycle 4 with instruction=0xE0000000, pc_out=4; outputs stable while accept=0.
- Continue from above: pulse accept for 1 cycle → mem_address 4,5,6,7; valid after 5 cycles with instruction=0xE3A00014, pc_out=8.
- Branch mid-fetch: branch_taken with branch_address=0x99 during byte_idx=2 → next mem_address=0x98, then 0x99, 0x9A, 0x9B; partial word discarded; valid with pc_out=0x9C.
- Freeze: freeze=1 for 2 cycles while mem_address=0x5 → mem_read=0, mem_address stays 0x5; instruction 0xE3A00014 still valid after 6 cycles total; freeze asserted in HOLD leaves valid=1.
- Wrap and priority: branch to 0xFFFFFFFC then accept → next fetch at 0x0. Assert accept and branch_taken (target 0x40) in the same HOLD cycle → next fetch at 0x40.
- Reset mid-fetch: drop rst_n at byte_idx=2 → valid=0, mem_read=0 immediately without clock; after release, fetch restarts at RESET_PC byte 0.
